// File: rtl/stage_mem_pkg.sv
// Shared constants for the memory-access pipeline stage: widths, mem_op and
// exception codes, and the bus FSM state encoding.
package stage_mem_pkg;

    localparam int WORD_W      = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int GPR_ADDR_W  = 5;

    localparam logic [1:0] MEM_OP_NOP = 2'd0;
    localparam logic [1:0] MEM_OP_LD  = 2'd1;
    localparam logic [1:0] MEM_OP_ST  = 2'd2;

    localparam logic [2:0] EXP_NONE     = 3'd0;
    localparam logic [2:0] EXP_INT      = 3'd1;
    localparam logic [2:0] EXP_OVF      = 3'd3;
    localparam logic [2:0] EXP_MISALIGN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/stage_mem_bus_ctrl.sv
// Data-bus sequencer for the MEM stage: request/ready handshake, read buffer,
// and the kill flag that turns a flushed in-flight access into a bubble.
import stage_mem_pkg::*;

module mem_bus_ctrl #(
    parameter int WORD_W      = stage_mem_pkg::WORD_W,
    parameter int WORD_ADDR_W = stage_mem_pkg::WORD_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_pending,
    input  logic                   i_rw,
    input  logic [WORD_ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0]      i_wr_data,
    output logic                   o_bus_req,
    output logic                   o_bus_rw,
    output logic [WORD_ADDR_W-1:0] o_bus_addr,
    output logic [WORD_W-1:0]      o_bus_wr_data,
    input  logic [WORD_W-1:0]      i_bus_rd_data,
    input  logic                   i_bus_rdy,
    output logic                   o_busy,
    output logic                   o_hold,
    output logic                   o_killed,
    output logic [WORD_W-1:0]      o_rd_buf
);

    mem_state_e             r_state;
    logic                   r_req;
    logic                   r_rw;
    logic [WORD_ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0]      r_wr_data;
    logic [WORD_W-1:0]      r_rd_buf;
    logic                   r_kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_rw      <= 1'b1;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_buf  <= '0;
            r_kill    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_pending && !i_flush) begin
                        r_req     <= 1'b1;
                        r_rw      <= i_rw;
                        r_addr    <= i_addr;
                        r_wr_data <= i_wr_data;
                        r_state   <= ST_ACCESS;
                    end
                end
                // The handshake always runs to completion; a flush only marks it dead.
                ST_ACCESS: begin
                    if (i_flush)
                        r_kill <= 1'b1;
                    if (i_bus_rdy) begin
                        r_rd_buf <= i_bus_rd_data;
                        r_req    <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!i_stall) begin
                        r_kill  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_bus_req     = r_req;
    assign o_bus_rw      = r_rw;
    assign o_bus_addr    = r_addr;
    assign o_bus_wr_data = r_wr_data;
    assign o_rd_buf      = r_rd_buf;
    assign o_busy        = ((r_state == ST_IDLE) && i_pending) || (r_state == ST_ACCESS);
    // A flushed, not-yet-launched access is bubbled directly rather than held.
    assign o_hold        = ((r_state == ST_IDLE) && i_pending && !i_flush) || (r_state == ST_ACCESS);
    assign o_killed      = (r_state == ST_DONE) && r_kill;

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: result selection, misaligned-access exception, and the
// MEM/WB pipeline register; bus sequencing lives in mem_bus_ctrl.
import stage_mem_pkg::*;

module stage_mem #(
    parameter int WORD_W      = stage_mem_pkg::WORD_W,
    parameter int WORD_ADDR_W = stage_mem_pkg::WORD_ADDR_W,
    parameter int GPR_ADDR_W  = stage_mem_pkg::GPR_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD_W-1:0]      ex_mem_wr_data,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [GPR_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [2:0]             ex_exp_code,
    input  logic [WORD_W-1:0]      ex_out,
    output logic                   bus_req,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0]      bus_wr_data,
    input  logic [WORD_W-1:0]      bus_rd_data,
    input  logic                   bus_rdy,
    output logic                   mem_busy,
    output logic [WORD_W-1:0]      fwd_data,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [GPR_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [2:0]             mem_exp_code,
    output logic [WORD_W-1:0]      mem_out
);

    logic              w_mem_access, w_misalign, w_pending;
    logic              w_hold, w_killed, w_gpr_we_;
    logic [WORD_W-1:0] w_rd_buf, w_out;

    assign w_mem_access = (ex_mem_op == MEM_OP_LD) || (ex_mem_op == MEM_OP_ST);
    // An incoming exception takes precedence over the alignment check.
    assign w_misalign   = w_mem_access && (ex_exp_code == EXP_NONE) && (ex_out[1:0] != 2'b00);
    assign w_pending    = ex_en && w_mem_access && (ex_exp_code == EXP_NONE) && (ex_out[1:0] == 2'b00);

    mem_bus_ctrl #(.WORD_W(WORD_W), .WORD_ADDR_W(WORD_ADDR_W)) u_bus_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_pending     (w_pending),
        .i_rw          (ex_mem_op == MEM_OP_LD),
        .i_addr        (ex_out[2 +: WORD_ADDR_W]),
        .i_wr_data     (ex_mem_wr_data),
        .o_bus_req     (bus_req),
        .o_bus_rw      (bus_rw),
        .o_bus_addr    (bus_addr),
        .o_bus_wr_data (bus_wr_data),
        .i_bus_rd_data (bus_rd_data),
        .i_bus_rdy     (bus_rdy),
        .o_busy        (mem_busy),
        .o_hold        (w_hold),
        .o_killed      (w_killed),
        .o_rd_buf      (w_rd_buf)
    );

    always_comb begin
        w_out     = ex_out;
        w_gpr_we_ = ex_gpr_we_;
        if (w_misalign) begin
            w_out     = '0;
            w_gpr_we_ = 1'b1;
        end else if (ex_mem_op == MEM_OP_LD) begin
            w_out = w_rd_buf;
        end else if (ex_mem_op == MEM_OP_ST) begin
            w_gpr_we_ = 1'b1;
        end
    end

    assign fwd_data = w_out;

    logic [WORD_ADDR_W-1:0] r_pc;
    logic                   r_en, r_br_flag, r_gpr_we_;
    logic [1:0]             r_ctrl_op;
    logic [GPR_ADDR_W-1:0]  r_dst_addr;
    logic [2:0]             r_exp_code;
    logic [WORD_W-1:0]      r_out;

    always_ff @(posedge clk) begin
        if (rst || ((flush || w_killed) && !(stall || w_hold))) begin
            r_pc       <= '0;
            r_en       <= 1'b0;
            r_br_flag  <= 1'b0;
            r_ctrl_op  <= '0;
            r_dst_addr <= '0;
            r_gpr_we_  <= 1'b1;
            r_exp_code <= EXP_NONE;
            r_out      <= '0;
        end else if (!(stall || w_hold)) begin
            r_pc       <= ex_pc;
            r_en       <= ex_en;
            r_br_flag  <= ex_br_flag;
            r_ctrl_op  <= w_misalign ? 2'b00 : ex_ctrl_op;
            r_dst_addr <= ex_dst_addr;
            r_gpr_we_  <= w_gpr_we_;
            r_exp_code <= w_misalign ? EXP_MISALIGN : ex_exp_code;
            r_out      <= w_out;
        end
    end

    assign mem_pc       = r_pc;
    assign mem_en       = r_en;
    assign mem_br_flag  = r_br_flag;
    assign mem_ctrl_op  = r_ctrl_op;
    assign mem_dst_addr = r_dst_addr;
    assign mem_gpr_we_  = r_gpr_we_;
    assign mem_exp_code = r_exp_code;
    assign mem_out      = r_out;

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage directly downstream of the EX stage. Consumes the EX/MEM pipeline register outputs, performs word-aligned load and store transactions on the data bus through a request/ready handshake, and raises `mem_busy` while a transaction is outstanding. Produces the MEM/WB pipeline register and a forwarding value.

## Interface
Parameters:
- `WORD_W`, 32: data word width.
- `WORD_ADDR_W`, 30: word address width.
- `GPR_ADDR_W`, 5: GPR address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`, `flush`  in  1 each  pipeline control from the pipeline controller.
- `ex_pc`  in  WORD_ADDR_W  program counter.
- `ex_en`  in  1  entry valid.
- `ex_br_flag`  in  1  branch flag.
- `ex_mem_op`  in  2  memory operation: 0 none, 1 load, 2 store, 3 reserved (treated as none).
- `ex_mem_wr_data`  in  WORD_W  store data.
- `ex_ctrl_op`  in  2  control-register operation.
- `ex_dst_addr`  in  GPR_ADDR_W  GPR destination address.
- `ex_gpr_we_`  in  1  GPR write enable, active-low.
- `ex_exp_code`  in  3  exception code.
- `ex_out`  in  WORD_W  ALU result; byte address for memory operations.
- `bus_req`  out  1  bus request.
- `bus_rw`  out  1  1 = read, 0 = write.
- `bus_addr`  out  WORD_ADDR_W  word address, `ex_out[31:2]`.
- `bus_wr_data`  out  WORD_W  store data.
- `bus_rd_data`  in  WORD_W  read data.
- `bus_rdy`  in  1  transfer complete.
- `mem_busy`  out  1  stall request to the pipeline controller.
- `fwd_data`  out  WORD_W  forwarding value; equals the `mem_out` next value.
- MEM/WB register outputs, all `out`: `mem_pc`, `mem_en`, `mem_br_flag`, `mem_ctrl_op`, `mem_dst_addr`, `mem_gpr_we_`, `mem_exp_code`, `mem_out`. Each has the same width as its `ex_*` counterpart.

## Operation
- An access is pending when all of the following hold: `ex_en`; `ex_mem_op` is 1 or 2; `ex_exp_code == 0`; `ex_out[1:0] == 0`.
- Misaligned access: `ex_mem_op` is 1 or 2 and `ex_out[1:0] != 0`.
  - No bus access is made.
  - Register loads `exp_code = 5`, `gpr_we_ = 1`, `ctrl_op = 0`, `out = 0`, and passes `pc`, `en`, `br_flag` through.
- Any nonzero incoming `ex_exp_code` passes through unchanged, and no access is made.
- FSM states: `IDLE`, `ACCESS`, `DONE`.
  - `IDLE`, access pending and no `flush` → register `bus_req = 1` together with `rw`, `addr`, `wr_data`; go to `ACCESS`.
  - `ACCESS`, `bus_rdy` → latch `bus_rd_data` into the read buffer, drop `bus_req`, go to `DONE`. Bus outputs are held stable until `bus_rdy`.
  - `DONE`, `~stall` → go to `IDLE`. With `stall`, stay in `DONE`.
- `mem_busy = (IDLE & pending) | ACCESS`.
- Result selection:
  - load → read buffer.
  - store → `ex_out`, with `gpr_we_` forced to 1.
  - otherwise → `ex_out`.
- MEM/WB register update priority:
  1. `rst`
  2. `stall` (hold)
  3. `flush` (bubble)
  4. killed access (bubble)
  5. exception override
  6. normal pass-through
- Bubble values: all fields 0, except `gpr_we_ = 1`.
- Flush during `ACCESS`:
  - The bus transaction completes; it is never abandoned mid-handshake.
  - A kill flag is set, and `DONE` commits a bubble.
  - The kill flag clears on entry to `IDLE`.
- Reset values, including mid-transaction:
  - All register outputs 0, except `mem_gpr_we_ = 1`.
  - `bus_req = 0`, `bus_rw = 1`, `bus_addr = 0`, `bus_wr_data = 0`.
  - FSM in `IDLE`, kill flag 0.

## Timing
- Non-memory entry: captured at the first rising edge with `~stall`. Latency 1 cycle; `mem_busy` stays 0.
- Load or store, pending in cycle T:
  - `mem_busy` high in T.
  - `bus_req` high from T+1 until the cycle `bus_rdy` is sampled.
  - Zero wait states (`bus_rdy` in T+1): `DONE` in T+2, MEM/WB valid from T+3.
  - Each wait cycle adds 1 cycle.
- `bus_rdy` is ignored outside `ACCESS`.
- `ex_*` inputs are held stable by the upstream stall while `mem_busy` is high.
- `fwd_data` is combinational from the current inputs and the read buffer.

## Structure
- Shared package holds:
  - the `WORD`, `WORD_ADDR`, and GPR width constants;
  - mem_op codes `MEM_OP_NOP`, `MEM_OP_LD`, `MEM_OP_ST`;
  - exception codes: 0 none, 1 interrupt, 3 overflow, 5 misaligned;
  - the FSM state encoding.
- Sub-module `mem_bus_ctrl` holds the FSM, bus registers, read buffer, and kill flag.
- `stage_mem` holds the result mux and the MEM/WB register.

## Test plan
- Reset mid-`ACCESS` (`bus_req = 1`): the next cycle shows `bus_req = 0`, `mem_en = 0`, `mem_gpr_we_ = 1`, and the FSM in `IDLE`.
- ALU pass-through: `ex_out = 0x12345678`, `mem_op = 0`, `dst = 7`, `we_ = 0` → one cycle later `mem_out = 0x12345678`, `mem_dst_addr = 7`, `mem_gpr_we_ = 0`; `mem_busy` never asserted.
- Load, `ex_out = 0x100`, `bus_rdy` after 2 wait cycles with `rd_data = 0xDEADBEEF`:
  - `bus_addr = 0x40`, `bus_rw = 1`;
  - `mem_busy` high for 4 cycles;
  - `mem_out = 0xDEADBEEF`.
- Store, `ex_out = 0x8`, `wr_data = 0xA5A5A5A5`, zero wait states:
  - `bus_rw = 0`, `bus_addr = 2`, `bus_wr_data = 0xA5A5A5A5`;
  - `mem_gpr_we_ = 1`.
- Misaligned load, `ex_out = 0x102`: no `bus_req`; `mem_exp_code = 5`, `mem_gpr_we_ = 1`, `mem_out = 0`.
- `flush` during `ACCESS`: `bus_req` is held until `bus_rdy`; the committed entry has `mem_en = 0`; the next load proceeds normally.
